seq_controller: RTL and testbench



---
 rtl/seq_controller.sv | 115 +++++++++++
 tb/tb_seq_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - clkEN prescaler and two-phase count sequencer with timeout
module seq_controller #(
    parameter int PRESC   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic co1,
    input  logic co2,
    output logic clkEN,
    output logic cnt1,
    output logic cnt2,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {IDLE, PH1, PH2, DONE, ERR} state_t;

    localparam logic [7:0] PRESC_MAX = 8'(PRESC - 1);
    localparam logic [7:0] TICK_MAX  = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nx;
    logic [7:0] presc_cnt;
    logic [7:0] tick_cnt;
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       start_pulse;
    logic       phase_entry;
    logic       in_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_cnt <= 8'd0;
            clkEN     <= 1'b0;
        end else if (presc_cnt == PRESC_MAX) begin
            presc_cnt <= 8'd0;
            clkEN     <= 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
            clkEN     <= 1'b0;
        end
    end

    // Two flops for metastability, the third only to find the rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_pulse = sync2 & ~sync3;
    assign in_phase    = (state == PH1) || (state == PH2);

    // A carry-out seen in the same cycle as the timeout still completes the phase.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start_pulse) state_nx = PH1;
                PH1: begin
                    if (co1)                       state_nx = PH2;
                    else if (tick_cnt == TICK_MAX) state_nx = ERR;
                end
                PH2: begin
                    if (co2)                       state_nx = DONE;
                    else if (tick_cnt == TICK_MAX) state_nx = ERR;
                end
                DONE: if (start_pulse) state_nx = PH1;
                ERR:  state_nx = ERR;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign phase_entry = ((state_nx == PH1) && (state != PH1)) ||
                         ((state_nx == PH2) && (state != PH2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= 8'd0;
            cnt1     <= 1'b0;
            cnt2     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (phase_entry) begin
                tick_cnt <= 8'd0;
            end else if (clkEN && in_phase && (tick_cnt != TICK_MAX)) begin
                tick_cnt <= tick_cnt + 8'd1;
            end
            cnt1 <= (state_nx == PH1);
            cnt2 <= (state_nx == PH2);
            busy <= (state_nx == PH1) || (state_nx == PH2);
            done <= (state_nx == DONE);
            err  <= (state_nx == ERR);
        end
    end

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - scoreboard bench for seq_controller with behavioural co=5 counters
module tb_seq_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic co1;
    logic co2;
    logic clkEN;
    logic cnt1;
    logic cnt2;
    logic busy;
    logic done;
    logic err;

    // 0: driven by behavioural counter, 1: forced low, 2: forced high
    int co1_mode = 0;
    int co2_mode = 0;
    logic [7:0] count1;
    logic [7:0] count2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int expv;

    seq_controller #(.PRESC(4), .TIMEOUT(15)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .co1(co1),
        .co2(co2),
        .clkEN(clkEN),
        .cnt1(cnt1),
        .cnt2(cnt2),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clock = ~clock;

    assign co1 = (co1_mode == 0) ? (count1 == 8'd5) : (co1_mode == 2);
    assign co2 = (co2_mode == 0) ? (count2 == 8'd5) : (co2_mode == 2);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            count1 <= 8'd0;
            count2 <= 8'd0;
        end else begin
            if (clkEN && cnt1) count1 <= count1 + 8'd1;
            if (clkEN && cnt2) count2 <= count2 + 8'd1;
        end
    end

    task automatic align_tick();
        int n;
        n = 0;
        while (!clkEN && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (clkEN !== 1'b1) begin
            errors++;
            $display("FAIL align_tick clkEN=%b required 1 within 10 clocks", clkEN);
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy=%b required 1 within 20 clocks", name, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({clkEN, cnt1, cnt2, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required 000000", {clkEN, cnt1, cnt2, busy, done, err});
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back((k == 4) ? 1 : 0);
            @(negedge clock);
            expv = exp_q.pop_front();
            checks++;
            if (clkEN !== expv[0]) begin
                errors++;
                $display("FAIL reset_first_clkEN edge=%0d got=%b required %0d", k, clkEN, expv);
            end
        end
    endtask

    task automatic test_two_phase_run();
        int lat;
        int t1;
        int t2;
        co1_mode = 0;
        co2_mode = 0;
        exp_q.push_back(3);
        exp_q.push_back(5);
        exp_q.push_back(5);
        exp_q.push_back(1);
        exp_q.push_back(5);
        exp_q.push_back(5);
        align_tick();
        start = 1'b1;
        lat = 0;
        while (!busy && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        expv = exp_q.pop_front();
        checks++;
        if (lat != expv) begin
            errors++;
            $display("FAIL start_latency got=%0d required %0d", lat, expv);
        end
        t1 = 0;
        t2 = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (clkEN && cnt1) t1++;
            if (clkEN && cnt2) t2++;
            @(negedge clock);
        end
        expv = exp_q.pop_front();
        checks++;
        if (t1 != expv) begin
            errors++;
            $display("FAIL ph1_ticks got=%0d required %0d", t1, expv);
        end
        expv = exp_q.pop_front();
        checks++;
        if (t2 != expv) begin
            errors++;
            $display("FAIL ph2_ticks got=%0d required %0d", t2, expv);
        end
        expv = exp_q.pop_front();
        checks++;
        if (done !== expv[0] || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_done done=%b busy=%b required 1/0", done, busy);
        end
        expv = exp_q.pop_front();
        checks++;
        if (count1 != 8'(expv)) begin
            errors++;
            $display("FAIL count1 got=%0d required %0d", count1, expv);
        end
        expv = exp_q.pop_front();
        checks++;
        if (count2 != 8'(expv)) begin
            errors++;
            $display("FAIL count2 got=%0d required %0d", count2, expv);
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_timeout();
        int ticks;
        co1_mode = 1;
        align_tick();
        start = 1'b1;
        wait_busy("timeout_start");
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            if (clkEN && cnt1) ticks++;
            if (ticks == 15) break;
            @(negedge clock);
        end
        exp_q.push_back(0);
        exp_q.push_back(1);
        @(negedge clock);
        expv = exp_q.pop_front();
        checks++;
        if (err !== expv[0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early err=%b busy=%b required 0/1", err, busy);
        end
        @(negedge clock);
        expv = exp_q.pop_front();
        checks++;
        if (err !== expv[0] || cnt1 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err err=%b cnt1=%b busy=%b required 1/0/0", err, cnt1, busy);
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_ignores_start err=%b busy=%b required 1/0", err, busy);
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if ({cnt1, cnt2, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL abort_idle got=%b required 00000", {cnt1, cnt2, busy, done, err});
        end
    endtask

    task automatic test_co_high_entry();
        logic [7:0] c1;
        co1_mode = 2;
        co2_mode = 1;
        c1 = count1;
        align_tick();
        start = 1'b1;
        wait_busy("co_entry_start");
        checks++;
        if (cnt1 !== 1'b1) begin
            errors++;
            $display("FAIL co_entry_ph1 cnt1=%b required 1", cnt1);
        end
        @(negedge clock);
        checks++;
        if (cnt1 !== 1'b0 || cnt2 !== 1'b1) begin
            errors++;
            $display("FAIL co_entry_ph2 cnt1=%b cnt2=%b required 0/1", cnt1, cnt2);
        end
        checks++;
        if (count1 != c1) begin
            errors++;
            $display("FAIL co_entry_count1 got=%0d required %0d", count1, c1);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_co_timeout_tie();
        int ticks;
        int n;
        co1_mode = 2;
        co2_mode = 1;
        start = 1'b1;
        n = 0;
        while (!cnt2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            if (clkEN && cnt2) ticks++;
            if (ticks == 15) break;
            @(negedge clock);
        end
        @(negedge clock);
        co2_mode = 2;
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL co_wins_tie done=%b err=%b required 1/0", done, err);
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_async_reset();
        int n;
        co1_mode = 2;
        co2_mode = 1;
        start = 1'b1;
        n = 0;
        while (!cnt2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if ({clkEN, cnt1, cnt2, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got=%b required 000000", {clkEN, cnt1, cnt2, busy, done, err});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            checks++;
            if (clkEN !== ((k == 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL post_reset_clkEN edge=%0d got=%b", k, clkEN);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int lat;
        logic rerun;
        co1_mode = 0;
        co2_mode = 0;
        start = 1'b1;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL held_first_done done=%b required 1", done);
        end
        rerun = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (busy || !done) rerun = 1'b1;
        end
        checks++;
        if (rerun !== 1'b0) begin
            errors++;
            $display("FAIL held_no_restart rerun=%b required 0", rerun);
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1;
        lat = 0;
        while (!busy && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL restart_latency got=%0d required 3", lat);
        end
        n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
        end
        rerun = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy || !done) rerun = 1'b1;
        end
        checks++;
        if (done !== 1'b1 || rerun !== 1'b0) begin
            errors++;
            $display("FAIL restart_single_run done=%b rerun=%b required 1/0", done, rerun);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_phase_run();
        test_timeout();
        test_co_high_entry();
        test_co_timeout_tie();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
